// File: rtl/spi_master_ctrl_pkg.sv
// Shared definitions for the SPI master controller: widths, ctrl codes,
// FSM state encoding and the 40-bit frame layout.
package spi_master_ctrl_pkg;

  localparam int unsigned W_SPI_CTRL     = 2;
  localparam int unsigned W_REG          = 5;
  localparam int unsigned W_CPU          = 32;
  localparam int unsigned SPI_FRAME_BITS = 40;
  localparam int unsigned SPI_CMD_BITS   = 8;
  localparam int unsigned W_DIV          = 8;
  localparam int unsigned W_BIT          = 6;

  localparam logic [W_SPI_CTRL-1:0] SPI_CTRL_NOP  = 2'b00;
  localparam logic [W_SPI_CTRL-1:0] SPI_CTRL_MOSI = 2'b01;
  localparam logic [W_SPI_CTRL-1:0] SPI_CTRL_MISO = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_DONE     = 3'd4
  } spi_state_e;

  // Frame as it appears on the wire, MSB first.
  typedef struct packed {
    logic [SPI_CMD_BITS-1:0] cmd;
    logic [W_CPU-1:0]        data;
  } spi_frame_t;

  // cmd = {rd, 2'b00, addr}; data phase carries wd for writes, zeros for reads.
  function automatic spi_frame_t build_frame(input logic             is_read,
                                             input logic [W_REG-1:0] addr,
                                             input logic [W_CPU-1:0] wd);
    spi_frame_t f;
    f.cmd  = {is_read, 2'b00, addr};
    f.data = is_read ? '0 : wd;
    return f;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: tick every CLK_DIV cycles, split into
// rise/fall enables according to the current SCLK level.
module spi_clk_div
  import spi_master_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic sclk,
  output logic tick_c,
  output logic rise_c,
  output logic fall_c
);

  logic [W_DIV-1:0] cnt;

  assign tick_c = (cnt == W_DIV'(CLK_DIV - 1));
  assign rise_c = tick_c & ~sclk;
  assign fall_c = tick_c & sclk;

  // Divider counter; restarts on clear and on every half-period tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W_DIV'(1);
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master controller: serializes CPU register read/write requests as
// 40-bit mode-0 frames. Optional SPI_CTRL_DEBUG_EN enables transfer and
// dropped-request $display messages (simulation only).
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [W_SPI_CTRL-1:0] ctrl,
  input  logic [W_REG-1:0]      addr,
  input  logic [W_CPU-1:0]      wd,
  output logic                  busy,
  output logic                  done,
  output logic                  dv_spi,
  output logic [W_CPU-1:0]      spi_out,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso
);

  spi_state_e                state;
  logic [SPI_FRAME_BITS-1:0] shreg;
  logic [W_CPU-1:0]          rx;
  logic [W_BIT-1:0]          bit_cnt;
  logic                      is_read;
  logic                      div_clr;
  logic                      tick_c;
  logic                      rise_c;
  logic                      fall_c;
  logic                      accept_c;

  assign accept_c = req && (state == ST_IDLE) &&
                    ((ctrl == SPI_CTRL_MOSI) || (ctrl == SPI_CTRL_MISO));
  // Divider held at zero outside timed states so each timed state starts fresh.
  assign div_clr  = (state == ST_IDLE) || (state == ST_DONE);
  // MOSI is the shift register MSB; zeros shift in behind the last bit.
  assign mosi     = shreg[SPI_FRAME_BITS-1];

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (div_clr),
    .sclk   (sclk),
    .tick_c (tick_c),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  // Transfer sequencer with registered bus and CPU-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      rx      <= '0;
      bit_cnt <= '0;
      is_read <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dv_spi  <= 1'b0;
      spi_out <= '0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
    end else begin
      done   <= 1'b0;
      dv_spi <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            state   <= ST_CS_SETUP;
            busy    <= 1'b1;
            cs_n    <= 1'b0;
            is_read <= (ctrl == SPI_CTRL_MISO);
            shreg   <= build_frame(ctrl == SPI_CTRL_MISO, addr, wd);
            rx      <= '0;
            bit_cnt <= '0;
          end
        end
        ST_CS_SETUP: begin
          if (tick_c) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (rise_c) begin
            sclk <= 1'b1;
            if (is_read && (bit_cnt >= W_BIT'(SPI_CMD_BITS))) begin
              rx <= {rx[W_CPU-2:0], miso};
            end
          end else if (fall_c) begin
            sclk  <= 1'b0;
            shreg <= {shreg[SPI_FRAME_BITS-2:0], 1'b0};
            if (bit_cnt == W_BIT'(SPI_FRAME_BITS - 1)) begin
              state   <= ST_CS_HOLD;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + W_BIT'(1);
            end
          end
        end
        ST_CS_HOLD: begin
          if (tick_c) begin
            state   <= ST_DONE;
            bit_cnt <= '0;
            cs_n    <= 1'b1;
            done    <= 1'b1;
            if (is_read) begin
              spi_out <= rx;
              dv_spi  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          bit_cnt <= '0;
          busy    <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SPI_CTRL_DEBUG_EN
  logic [W_REG-1:0] dbg_addr;
  logic [W_CPU-1:0] dbg_wd;

  // Remember the accepted request for the completion message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_addr <= '0;
      dbg_wd   <= '0;
    end else if (accept_c) begin
      dbg_addr <= addr;
      dbg_wd   <= wd;
    end
  end

  // Completion and dropped-request messages.
  always @(posedge clk) begin
    if (rst_n && done) begin
      $display("spi_master_ctrl: %s addr=%02h data=%08h",
               is_read ? "READ " : "WRITE", dbg_addr, is_read ? spi_out : dbg_wd);
    end
    if (rst_n && req && busy) begin
      $display("spi_master_ctrl: warning, req dropped while busy (ctrl=%02b)", ctrl);
    end
  end
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench: two controller lanes (CLK_DIV=2 and CLK_DIV=1), each
// with a behavioural mode-0 slave, checked against frame/timing expectations.
module tb_spi_master_ctrl;
  import spi_master_ctrl_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  int unsigned cyc   = 0;
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req     [2];
  logic [1:0]  ctrl    [2];
  logic [4:0]  addr    [2];
  logic [31:0] wd      [2];
  logic        busy    [2];
  logic        done    [2];
  logic        dv      [2];
  logic [31:0] spi_out [2];
  logic        sclk    [2];
  logic        cs_n    [2];
  logic        mosi    [2];
  logic        miso    [2];
  logic [31:0] slave_tx[2];
  logic [39:0] s_rx    [2];
  logic [7:0]  s_cnt   [2];
  logic [15:0] done_cnt[2];
  logic [31:0] model_out[2];

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic        m_miso    = 1'b0;
    logic [39:0] m_tx      = '0;
    logic [39:0] m_rx      = '0;
    logic [7:0]  m_cnt     = '0;
    logic [15:0] m_done    = '0;
    logic        prev_sclk = 1'b0;
    logic        prev_cs   = 1'b1;

    spi_master_ctrl #(.CLK_DIV(2 - g)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req[g]),
      .ctrl    (ctrl[g]),
      .addr    (addr[g]),
      .wd      (wd[g]),
      .busy    (busy[g]),
      .done    (done[g]),
      .dv_spi  (dv[g]),
      .spi_out (spi_out[g]),
      .sclk    (sclk[g]),
      .cs_n    (cs_n[g]),
      .mosi    (mosi[g]),
      .miso    (miso[g])
    );

    assign miso[g]     = m_miso;
    assign s_rx[g]     = m_rx;
    assign s_cnt[g]    = m_cnt;
    assign done_cnt[g] = m_done;

    // Mode-0 slave: first bit on cs_n fall, next bit after each SCLK fall,
    // MOSI captured after each SCLK rise. Returns {8'h00, slave_tx}.
    always @(negedge clk) begin
      if (prev_cs && !cs_n[g]) begin
        m_tx   = {8'h00, slave_tx[g]};
        m_miso = m_tx[39];
        m_rx   = '0;
        m_cnt  = '0;
      end else if (!cs_n[g]) begin
        if (!prev_sclk && sclk[g]) begin
          m_rx  = {m_rx[38:0], mosi[g]};
          m_cnt = m_cnt + 8'd1;
        end
        if (prev_sclk && !sclk[g]) begin
          m_tx   = m_tx << 1;
          m_miso = m_tx[39];
        end
      end
      if (done[g]) m_done = m_done + 16'd1;
      prev_sclk = sclk[g];
      prev_cs   = cs_n[g];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned cd_of(input int g);
    return (g == 0) ? 2 : 1;
  endfunction

  task automatic check_reset_vals(input string tag, input int g);
    check({tag, "_ctl"}, 64'({busy[g], done[g], dv[g], sclk[g], cs_n[g], mosi[g]}),
          64'(6'b000010));
    check({tag, "_out"}, 64'(spi_out[g]), 64'(0));
  endtask

  // One request through the lane; checks frame, read data, timing and strobes.
  task automatic xfer(input int g, input logic [1:0] c, input logic [4:0] a,
                      input logic [31:0] w, input logic [31:0] sw);
    int unsigned cd, t1, done_at, busy_n, done_n, dv_n;
    logic        rd;
    logic [39:0] exp_frame;
    logic [31:0] exp_out, out_at_done;
    string       tg;
    cd        = cd_of(g);
    rd        = (c == SPI_CTRL_MISO);
    exp_frame = {rd, 2'b00, a, rd ? 32'h0 : w};
    exp_out   = rd ? sw : model_out[g];
    tg        = $sformatf("L%0d_%s_%02h", g, rd ? "rd" : "wr", a);
    @(negedge clk);
    slave_tx[g] = sw;
    req[g] = 1'b1; ctrl[g] = c; addr[g] = a; wd[g] = w;
    @(negedge clk);
    req[g] = 1'b0; ctrl[g] = SPI_CTRL_NOP; addr[g] = 5'($urandom); wd[g] = $urandom;
    t1 = cyc; busy_n = 0; done_n = 0; dv_n = 0; done_at = 0; out_at_done = ~exp_out;
    check({tg, "_cs_low"}, 64'(cs_n[g]), 64'(0));
    for (int k = 0; k < 400; k++) begin
      if (!busy[g]) break;
      busy_n++;
      if (done[g]) begin
        done_n++;
        done_at     = cyc;
        out_at_done = spi_out[g];
      end
      if (dv[g]) dv_n++;
      @(negedge clk);
    end
    check({tg, "_busy_cycles"}, 64'(busy_n), 64'(82 * cd + 1));
    check({tg, "_done_count"}, 64'(done_n), 64'(1));
    check({tg, "_done_cycle"}, 64'(done_at - t1 + 1), 64'(1 + 82 * cd));
    check({tg, "_dv_count"}, 64'(dv_n), 64'(rd ? 1 : 0));
    check({tg, "_spi_out"}, 64'(out_at_done), 64'(exp_out));
    check({tg, "_slave_bits"}, 64'(s_cnt[g]), 64'(40));
    check({tg, "_frame"}, 64'(s_rx[g]), 64'(exp_frame));
    check({tg, "_idle_bus"}, 64'({cs_n[g], sclk[g]}), 64'(2'b10));
    model_out[g] = exp_out;
  endtask

  // req held high for two full periods: exactly two frames, two idle cs_n cycles between.
  task automatic collide(input int g);
    int unsigned p, falls, hi, d0;
    logic        prev;
    p = 82 * cd_of(g) + 2;
    falls = 0; hi = 0; prev = 1'b1;
    d0 = 32'(done_cnt[g]);
    @(negedge clk);
    slave_tx[g] = $urandom;
    req[g] = 1'b1; ctrl[g] = SPI_CTRL_MOSI; addr[g] = 5'($urandom); wd[g] = $urandom;
    for (int k = 0; k < 2 * p; k++) begin
      @(negedge clk);
      if (prev && !cs_n[g]) falls++;
      else if (falls == 1 && cs_n[g]) hi++;
      prev = cs_n[g];
    end
    req[g] = 1'b0; ctrl[g] = SPI_CTRL_NOP;
    for (int k = 0; k < 400 && busy[g]; k++) @(negedge clk);
    check($sformatf("L%0d_coll_frames", g), 64'(falls), 64'(2));
    check($sformatf("L%0d_coll_gap", g), 64'(hi), 64'(2));
    check($sformatf("L%0d_coll_dones", g), 64'(32'(done_cnt[g]) - d0), 64'(2));
    check($sformatf("L%0d_coll_idle", g), 64'(busy[g]), 64'(0));
  endtask

  // ctrl 11 / 00 with req high must never start a transfer.
  task automatic nop_req(input int g);
    int unsigned seen;
    seen = 0;
    @(negedge clk);
    req[g] = 1'b1; ctrl[g] = 2'b11;
    repeat (6) begin
      @(negedge clk);
      if (busy[g] || !cs_n[g]) seen++;
    end
    ctrl[g] = SPI_CTRL_NOP;
    repeat (6) begin
      @(negedge clk);
      if (busy[g] || !cs_n[g]) seen++;
    end
    req[g] = 1'b0;
    check($sformatf("L%0d_nop_busy", g), 64'(seen), 64'(0));
  endtask

  // Reset asserted at the start of bit 20 of a read.
  task automatic reset_mid(input int g);
    int unsigned cd, d0;
    cd = cd_of(g);
    @(negedge clk);
    slave_tx[g] = $urandom;
    req[g] = 1'b1; ctrl[g] = SPI_CTRL_MISO; addr[g] = 5'($urandom);
    @(negedge clk);
    req[g] = 1'b0; ctrl[g] = SPI_CTRL_NOP;
    repeat (cd + 40 * cd) @(negedge clk);
    check($sformatf("L%0d_mid_busy", g), 64'(busy[g]), 64'(1));
    d0 = 32'(done_cnt[g]);
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals($sformatf("L%0d_mid_rst", g), g);
    model_out[0] = '0;
    model_out[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check($sformatf("L%0d_mid_no_done", g), 64'(32'(done_cnt[g]) - d0), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned viol;
    for (int g = 0; g < 2; g++) begin
      req[g] = 1'b0; ctrl[g] = SPI_CTRL_NOP; addr[g] = '0; wd[g] = '0;
      slave_tx[g] = '0; model_out[g] = '0;
    end
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) check_reset_vals($sformatf("L%0d_reset", g), g);
    rst_n = 1'b1;
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) if (cs_n[g] !== 1'b1 || sclk[g] !== 1'b0) viol++;
    end
    check("idle_after_reset", 64'(viol), 64'(0));

    xfer(0, SPI_CTRL_MOSI, 5'h03, 32'hDEADBEEF, 32'h13579BDF);
    xfer(0, SPI_CTRL_MISO, 5'h1F, 32'hFFFFFFFF, 32'h00000016);
    xfer(0, SPI_CTRL_MOSI, 5'h0A, 32'h00000000, 32'hFFFFFFFF);
    xfer(1, SPI_CTRL_MISO, 5'h00, 32'h12345678, 32'hA5A5A5A5);
    xfer(1, SPI_CTRL_MOSI, 5'h15, 32'h80000001, 32'h5A5A5A5A);

    nop_req(0);
    collide(0);
    collide(1);

    reset_mid(0);
    xfer(0, SPI_CTRL_MISO, 5'h11, 32'h0, 32'hCAFEF00D);

    for (int i = 0; i < 6; i++) begin
      for (int g = 0; g < 2; g++) begin
        xfer(g, ($urandom_range(0, 1) == 0) ? SPI_CTRL_MOSI : SPI_CTRL_MISO,
             5'($urandom), $urandom, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
